// File: rtl/sd_pkg.sv
// Shared definitions for the SD command engine: register map,
// STATUS bit positions, FSM states and the CRC7 polynomial.
package sd_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_ARG    = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_RESP0  = 3'd3;
  localparam logic [2:0] ADDR_RESP1  = 3'd4;
  localparam logic [2:0] ADDR_DIV    = 3'd5;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_CRC_ERR = 3;
  localparam int ST_END_ERR = 4;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_TAIL
  } sd_state_e;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator, MSB-first data, zero initial value.
// Clear takes priority over enable.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic fb;

  assign fb = o_crc[6] ^ i_bit;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_crc <= '0;
    end else if (i_clear) begin
      o_crc <= '0;
    end else if (i_enable) begin
      o_crc <= {o_crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: 48-bit command out, optional 48-bit response in.
// Define SD_CMD_CRC_CHECK_EN to build the receive CRC7 check.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIV  = 8'd124,
  parameter int         RESP_TIMEOUT = 64
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [2:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_sd_clk,
  output logic        o_cmd_oe,
  output logic        o_cmd,
  input  logic        i_cmd
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  sd_state_e     state_q, state_d;
  logic [7:0]    div_reg, div_act, div_cnt;
  logic [31:0]   arg_q, status;
  logic          no_resp_q, sd_clk_q, fall_d;
  logic          cmd_q, oe_q, sync1, cmd_sync;
  logic [38:0]   tx_sr;
  logic [5:0]    bit_cnt, rcnt;
  logic [TW-1:0] wcnt;
  logic [3:0]    tcnt;
  logic [45:0]   rx_sr, rx_next;
  logic [6:0]    crc_tx;
  logic          done_q, tmo_q, crc_err_q, end_err_q;
  logic          busy, tick, rise_tick, fall_tick;
  logic          start, rd, tx_en, last_rx, finish;

  assign busy      = state_q != S_IDLE;
  assign start     = i_request && i_rw && i_address == ADDR_CTRL && !busy;
  assign rd        = i_request && !i_rw;
  assign tick      = busy && div_cnt == div_act;
  assign rise_tick = tick && !sd_clk_q;
  assign fall_tick = tick && sd_clk_q;
  assign tx_en     = state_q == S_SEND && fall_d && bit_cnt < 6'd39;
  assign rx_next   = {rx_sr[44:0], cmd_sync};
  assign last_rx   = state_q == S_RECV && rise_tick && rcnt == 6'd46;
  assign finish    = state_q == S_TAIL && state_d == S_IDLE;

  assign status = {27'd0, end_err_q, crc_err_q, tmo_q, done_q, busy};

  assign o_busy   = busy;
  assign o_sd_clk = sd_clk_q;
  assign o_cmd_oe = oe_q;
  assign o_cmd    = cmd_q;

  // Start bit is always 0 and leaves a zero CRC unchanged, so the
  // generator only needs bits 1..39.
  sd_crc7 u_crc_tx (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (start),
    .i_enable (tx_en),
    .i_bit    (tx_sr[38]),
    .o_crc    (crc_tx)
  );

`ifdef SD_CMD_CRC_CHECK_EN
  logic [6:0] crc_rx;
  logic       rx_en;

  assign rx_en = state_q == S_RECV && rise_tick && rcnt < 6'd39;

  sd_crc7 u_crc_rx (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (start),
    .i_enable (rx_en),
    .i_bit    (cmd_sync),
    .o_crc    (crc_rx)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      crc_err_q <= 1'b0;
    end else if (start) begin
      crc_err_q <= 1'b0;
    end else if (last_rx) begin
      crc_err_q <= crc_rx != rx_next[7:1];
    end
  end
`else
  assign crc_err_q = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1    <= 1'b1;
      cmd_sync <= 1'b1;
      state_q  <= S_IDLE;
    end else begin
      sync1    <= i_cmd;
      cmd_sync <= sync1;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_SEND;
      S_SEND: begin
        if (fall_d && bit_cnt == 6'd47)
          state_d = no_resp_q ? S_TAIL : S_WAIT;
      end
      S_WAIT: begin
        if (rise_tick) begin
          if (!cmd_sync)
            state_d = S_RECV;
          else if (wcnt == TW'(RESP_TIMEOUT - 1))
            state_d = S_TAIL;
        end
      end
      S_RECV: if (last_rx) state_d = S_TAIL;
      S_TAIL: if (fall_tick && tcnt == 4'd8) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_ready <= 1'b0;
      o_rdata <= '0;
      arg_q   <= '0;
      div_reg <= DEFAULT_DIV;
      done_q  <= 1'b0;
    end else begin
      o_ready <= i_request;
      o_rdata <= '0;
      if (i_request && i_rw && i_address == ADDR_ARG)
        arg_q <= i_wdata;
      if (i_request && i_rw && i_address == ADDR_DIV)
        div_reg <= i_wdata[7:0];
      if (rd) begin
        unique case (1'b1)
          i_address == ADDR_ARG:    o_rdata <= arg_q;
          i_address == ADDR_STATUS: o_rdata <= status;
          i_address == ADDR_RESP0:  o_rdata <= rx_sr[39:8];
          i_address == ADDR_RESP1:
            o_rdata <= {17'd0, rx_sr[7:1], 2'd0, rx_sr[45:40]};
          i_address == ADDR_DIV:    o_rdata <= {24'd0, div_reg};
          default:                  o_rdata <= '0;
        endcase
      end
      if (rd && i_address == ADDR_STATUS)
        done_q <= 1'b0;
      // A done-set in the same cycle as a STATUS read must survive.
      if (finish)
        done_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      div_act   <= DEFAULT_DIV;
      div_cnt   <= '0;
      sd_clk_q  <= 1'b0;
      fall_d    <= 1'b0;
      no_resp_q <= 1'b0;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      tcnt      <= '0;
      rx_sr     <= '0;
      cmd_q     <= 1'b1;
      oe_q      <= 1'b0;
      tmo_q     <= 1'b0;
      end_err_q <= 1'b0;
    end else begin
      fall_d <= fall_tick;
      if (!busy || tick) div_cnt <= '0;
      else div_cnt <= div_cnt + 8'd1;
      if (!busy) sd_clk_q <= 1'b0;
      else if (tick) sd_clk_q <= !sd_clk_q;
      if (state_q != S_WAIT) wcnt <= '0;
      else if (rise_tick) wcnt <= wcnt + TW'(1);
      if (state_q != S_RECV) rcnt <= '0;
      else if (rise_tick) rcnt <= rcnt + 6'd1;
      if (state_q != S_TAIL) tcnt <= '0;
      else if (rise_tick) tcnt <= tcnt + 4'd1;
      if (start) begin
        div_act   <= div_reg;
        no_resp_q <= i_wdata[8];
        tx_sr     <= {1'b1, i_wdata[5:0], arg_q};
        bit_cnt   <= '0;
        cmd_q     <= 1'b0;
        oe_q      <= 1'b1;
        tmo_q     <= 1'b0;
        end_err_q <= 1'b0;
      end
      // Next bit goes out one i_clock after the falling SD edge.
      if (state_q == S_SEND && fall_d) begin
        bit_cnt <= bit_cnt + 6'd1;
        tx_sr   <= {tx_sr[37:0], 1'b0};
        if (bit_cnt < 6'd39)
          cmd_q <= tx_sr[38];
        else if (bit_cnt < 6'd46)
          cmd_q <= crc_tx[3'(6'd45 - bit_cnt)];
        else
          cmd_q <= 1'b1;
        if (bit_cnt == 6'd47)
          oe_q <= 1'b0;
      end
      if (state_q == S_WAIT && rise_tick && cmd_sync &&
          wcnt == TW'(RESP_TIMEOUT - 1))
        tmo_q <= 1'b1;
      if (state_q == S_RECV && rise_tick)
        rx_sr <= rx_next;
      if (last_rx)
        end_err_q <= !cmd_sync;
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: bus reads, transmitted frames
// and a simple card model answering on the CMD line.
`timescale 1ns/1ps
module tb_sd_cmd_engine;

`ifdef SD_CMD_CRC_CHECK_EN
  localparam logic [31:0] CRC_BIT = 32'h8;
`else
  localparam logic [31:0] CRC_BIT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [2:0]  i_address = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_ready, o_busy, o_sd_clk, o_cmd_oe, o_cmd;
  logic        card_cmd = 1'b1;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       nm;
  } bus_t;

  bus_t        bus_q[$];
  logic [47:0] tx_q[$];
  int          ncmp = 0;
  int          nerr = 0;

  logic        req_q = 1'b0;
  logic        sd_prev = 1'b0;
  logic [47:0] txsh = '0;
  int          nbits = 0;
  int          rel_rises = 0;
  bit          card_on = 1'b0;
  logic [47:0] card_fr = '0;
  int          card_dly = 0;
  int          card_n = 0;

  always #5 clk = ~clk;

  sd_cmd_engine dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .i_request (i_request),
    .i_rw      (i_rw),
    .i_address (i_address),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_sd_clk  (o_sd_clk),
    .o_cmd_oe  (o_cmd_oe),
    .o_cmd     (o_cmd),
    .i_cmd     (card_cmd)
  );

  task automatic check(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) req_q <= i_request;

  // Monitor: bus acknowledge/read data, TX frame capture, card model.
  always @(negedge clk) begin
    bit   rise, fall;
    bus_t e;
    rise = o_sd_clk && !sd_prev;
    fall = !o_sd_clk && sd_prev;
    sd_prev = o_sd_clk;
    if (i_reset) begin
      nbits = 0;
      card_on = 1'b0;
      card_cmd = 1'b1;
    end else begin
      if (o_ready || req_q)
        check("ready_timing", 48'(o_ready), 48'(req_q));
      if (o_ready) begin
        if (bus_q.size() == 0) begin
          check("ready_unexpected", 48'(o_ready), 48'd0);
        end else begin
          e = bus_q.pop_front();
          if (e.chk) check(e.nm, 48'(o_rdata), 48'(e.exp));
        end
      end
      if (rise && o_cmd_oe) begin
        txsh = {txsh[46:0], o_cmd};
        nbits++;
        if (nbits == 48) begin
          nbits = 0;
          if (tx_q.size() == 0) check("tx_unexpected", txsh, 48'd0);
          else check("tx_frame", txsh, tx_q.pop_front());
        end
      end
      if (rise && o_busy && !o_cmd_oe) rel_rises++;
      if (fall && card_on) begin
        if (card_dly > 0) begin
          card_dly--;
        end else if (card_n < 48) begin
          card_cmd = card_fr[47 - card_n];
          card_n++;
        end else begin
          card_cmd = 1'b1;
          card_on = 1'b0;
        end
      end
    end
  end

  task automatic bus(input bit rw, input logic [2:0] a,
                     input logic [31:0] d, input bit chk,
                     input logic [31:0] exp, input string nm);
    bus_t e;
    @(negedge clk);
    e.chk = chk;
    e.exp = exp;
    e.nm = nm;
    bus_q.push_back(e);
    i_request = 1'b1;
    i_rw = rw;
    i_address = a;
    i_wdata = d;
    @(negedge clk);
    i_request = 1'b0;
    i_rw = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, '0, "write");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                    input string nm);
    bus(1'b0, a, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic arm_card(input logic [47:0] fr, input int dly);
    card_fr = fr;
    card_dly = dly;
    card_n = 0;
    card_on = 1'b1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (o_busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 48'(o_busy), 48'd0);
  endtask

  // 48 falls cover the outgoing frame; start bit then follows 5 clocks on.
  localparam int CARD_DLY = 53;

  initial begin
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 48'(o_ready), 48'd0);
    check("rst_rdata", 48'(o_rdata), 48'd0);
    check("rst_busy", 48'(o_busy), 48'd0);
    check("rst_sdclk", 48'(o_sd_clk), 48'd0);
    check("rst_oe", 48'(o_cmd_oe), 48'd0);
    check("rst_cmd", 48'(o_cmd), 48'd1);
    rd(3'd5, 32'd124, "rst_div");
    rd(3'd2, 32'd0, "rst_status");
    rd(3'd1, 32'd0, "rst_arg");
    rd(3'd3, 32'd0, "rst_resp0");
    rd(3'd4, 32'd0, "rst_resp1");

    // CMD0, no response, fastest clock
    wr(3'd5, 32'd0);
    wr(3'd1, 32'd0);
    tx_q.push_back(48'h40_00000000_95);
    wr(3'd0, 32'h100);
    check("cmd0_busy_rise", 48'(o_busy), 48'd1);
    wait_idle(2000);
    rd(3'd2, 32'h2, "cmd0_status");
    rd(3'd2, 32'h0, "cmd0_status_clr");

    // CMD8 with response; CTRL while busy ignored, ARG still stored
    wr(3'd1, 32'h1AA);
    arm_card(48'h08_000001AA_13, CARD_DLY);
    tx_q.push_back(48'h48_000001AA_87);
    wr(3'd0, 32'd8);
    wr(3'd0, 32'h105);
    wr(3'd1, 32'hDEADBEEF);
    wait_idle(3000);
    rd(3'd2, 32'h2, "cmd8_status");
    rd(3'd3, 32'h1AA, "cmd8_resp0");
    rd(3'd4, 32'h0908, "cmd8_resp1");
    rd(3'd1, 32'hDEADBEEF, "arg_while_busy");

    // No card at DIV=1: 64 WAIT clocks plus 8 tail clocks, CMD released
    wr(3'd5, 32'd1);
    wr(3'd1, 32'h1AA);
    tx_q.push_back(48'h48_000001AA_87);
    rel_rises = 0;
    wr(3'd0, 32'd8);
    wait_idle(5000);
    check("timeout_clocks", 48'(rel_rises), 48'd72);
    rd(3'd2, 32'h6, "timeout_status");

    // One flipped argument bit in the response
    wr(3'd5, 32'd0);
    arm_card(48'h08_000001AB_13, CARD_DLY);
    tx_q.push_back(48'h48_000001AA_87);
    wr(3'd0, 32'd8);
    wait_idle(3000);
    rd(3'd2, 32'h2 | CRC_BIT, "crc_status");
    rd(3'd3, 32'h1AB, "crc_resp0");

    // End bit 0
    arm_card(48'h08_000001AA_12, CARD_DLY);
    tx_q.push_back(48'h48_000001AA_87);
    wr(3'd0, 32'd8);
    wait_idle(3000);
    rd(3'd2, 32'h12, "end_status");
    rd(3'd4, 32'h0908, "end_resp1");

    // Reset in the middle of SEND
    tx_q.push_back(48'h40_00000000_95);
    wr(3'd0, 32'h100);
    repeat (20) @(negedge clk);
    check("mid_send_oe", 48'(o_cmd_oe), 48'd1);
    i_reset = 1'b1;
    @(negedge clk);
    check("mid_rst_oe", 48'(o_cmd_oe), 48'd0);
    check("mid_rst_busy", 48'(o_busy), 48'd0);
    check("mid_rst_cmd", 48'(o_cmd), 48'd1);
    @(negedge clk);
    i_reset = 1'b0;
    tx_q.delete();
    rd(3'd2, 32'h0, "mid_rst_status");
    rd(3'd5, 32'd124, "mid_rst_div");

    repeat (4) @(negedge clk);
    check("tx_pending", 48'(tx_q.size()), 48'd0);
    check("bus_pending", 48'(bus_q.size()), 48'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Hardware SD command-line engine that replaces software bit-banging of SD_CMD for command/response traffic. It sits on the CPU peripheral bus next to the GPIO-style SD pin block. It drives the SD clock and CMD pin through the SoC pin mux while `o_busy` is high. It serialises a 48-bit command frame with generated CRC7, waits for the card's start bit and captures a 48-bit response.

## Interface
- `DEFAULT_DIV`, 8'd124: reset value of the clock divider (≈400 kHz from 100 MHz).
- `RESP_TIMEOUT`, 64: SD clock periods to wait for a response start bit.
- `i_clock` in 1: system clock; everything is synchronous to its rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_request` in 1: bus access strobe, one cycle.
- `i_rw` in 1: 1 = write, 0 = read.
- `i_address` in 3: register select.
- `i_wdata` in 32: write data.
- `o_rdata` out 32: read data, registered.
- `o_ready` out 1: access acknowledge.
- `o_busy` out 1: engine owns the SD pins; the pin mux selects this block.
- `o_sd_clk` out 1: SD clock.
- `o_cmd_oe` out 1: CMD output enable.
- `o_cmd` out 1: CMD output value.
- `i_cmd` in 1: CMD pin input. The pin is pulled up; it is sampled through a 2-flop synchroniser.

## Operation
- Register map:
  - 0 CTRL (W): [5:0] command index; [8] no-response; a write starts a transaction.
  - 1 ARG (R/W): 32-bit argument.
  - 2 STATUS (R): [0] busy, [1] done, [2] timeout, [3] crc_err, [4] end_err. Reading STATUS clears done.
  - 3 RESP0 (R): response bits [39:8], i.e. the argument/status field.
  - 4 RESP1 (R): [5:0] response index, [14:8] received CRC7.
  - 5 DIV (R/W): [7:0] divider.
- A CTRL write while busy is ignored; the ARG write is still stored.
- Frame: start 0, transmission 1, index[5:0], ARG[31:0], CRC7, end 1. Total 48 bits, MSB first.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits while shifting.
- FSM states and transitions:
  - IDLE -> SEND on CTRL write.
  - SEND (48 bits) -> TAIL if no-response, else -> WAIT.
  - WAIT: releases CMD (`o_cmd_oe`=0). A 0 sampled within `RESP_TIMEOUT` rising edges -> RECV. Otherwise set timeout -> TAIL.
  - RECV shifts 47 further bits; the first of these is the transmission bit, expected 0.
  - TAIL issues 8 idle clocks with CMD released, then sets done -> IDLE.
- Response checks:
  - A received end bit that is not 1 sets end_err.
  - With the CRC macro enabled, a mismatch sets crc_err (see Configuration).
- Error flags are cleared on the next CTRL start.
- Clock: `o_sd_clk` toggles every DIV+1 `i_clock` cycles while busy and is held low in IDLE.
  - CMD output changes one `i_clock` after a falling SD_CLK edge.
  - Input is sampled on the rising-edge tick.

## Timing
- `o_ready` is asserted exactly one cycle after any `i_request`. Reads return data in the same cycle as `o_ready`. `o_ready` is low when `i_request` is absent.
- Reset values:
  - `o_rdata`=0, `o_ready`=0, `o_busy`=0, `o_sd_clk`=0, `o_cmd_oe`=0, `o_cmd`=1.
  - DIV=`DEFAULT_DIV`; all status bits, ARG and RESP are 0.
- `o_busy` rises the cycle after the accepted CTRL write and falls in the same cycle done sets.
- One SD bit = 2·(DIV+1) `i_clock` cycles. DIV=0 gives SD_CLK = `i_clock`/2.
- A DIV write while busy takes effect at the next transaction.
- Reset mid-transaction: FSM returns to IDLE immediately, CMD is released, and no done is set.
- If a STATUS read and done-set land in the same cycle, the set wins. The read returns the old value, so the flag is seen on the next read.

## Configuration
- `SD_CMD_CRC_CHECK_EN` defined: RECV computes CRC7 over the 40 received bits and compares it with the received CRC, setting crc_err on mismatch.
- Undefined: no receive CRC logic is built; crc_err reads 0. RESP1[14:8] still reports the received CRC.

## Structure
- Shared package `sd_pkg`:
  - register address constants;
  - STATUS bit positions;
  - FSM state enum;
  - CRC7 polynomial constant.
- Sub-module `sd_crc7`: serial CRC7 with clear, enable and data-bit input. It is instantiated once for TX. It is instantiated a second time for RX only under `SD_CMD_CRC_CHECK_EN`.

## Test plan
- Reset:
  - `i_reset` pulse -> all outputs at their reset values; DIV reads 124; STATUS reads 0.
- CMD0 with no response:
  - Stimulus: DIV=0, ARG=0, CTRL=0x100.
  - Expected CMD bits: 0x40_00000000_95 (CRC7 0x4A).
  - Then 8 idle clocks, done=1, busy=0.
- CMD8 with response:
  - Stimulus: ARG=0x1AA, CTRL=8. The card model answers 0x08_000001AA_13 after 5 SD clocks.
  - Expected: RESP0=0x000001AA, RESP1=0x0908 (CRC 0x09, index 8), no errors.
- No card:
  - Stimulus: CMD stays high.
  - Expected: timeout=1 after exactly 64 SD clocks in WAIT, then TAIL, then done.
- Corrupted response:
  - Stimulus: the card flips one argument bit.
  - Expected: crc_err=1 with the macro defined, 0 without. An end bit of 0 -> end_err=1.
- Protocol corner cases:
  - A CTRL write while busy is ignored.
  - Reset asserted mid-SEND -> IDLE, `o_cmd_oe`=0.
  - `o_ready` is asserted exactly 1 cycle after every request.
